aes_cipher_collector: RTL and testbench
=======================================

Name: aes_cipher_collector

Overview:
Downstream stage of the byte-serial AES encryption core. It consumes the core's ciphertext byte stream (`ready` strobe plus `state_out_byte`) and reassembles each 16-byte burst into a 128-bit block, MSB byte first. Completed blocks go into a 2-entry output FIFO, which the consumer reads through a valid/ready handshake. Framing errors and FIFO overflow are reported as sticky flags, and accepted blocks are counted.

Parameters:
SKIP_FIRST, 1, number of leading strobe-high cycles discarded per burst (0 or 1). The core's first ready-high cycle carries a stale byte.
FIFO_DEPTH, 2, output block buffer depth. Fixed at 2 for this revision.

Ports:
clk  input  1  single clock, rising edge
rst  input  1  reset, asynchronous, active-low
ct_byte_in  input  8  ciphertext byte from the encrypt core
ct_strobe_in  input  1  core's ready output; high while the burst is on ct_byte_in
clear  input  1  synchronous clear of sticky flags and block_count
out_ready  input  1  consumer accepts out_data this cycle
out_valid  output  1  FIFO non-empty
out_data  output  128  FIFO head block; byte 0 received is in [127:120]
block_count  output  16  number of blocks pushed into the FIFO, wrapping
short_err  output  1  sticky: strobe dropped before 16 bytes were captured
long_err  output  1  sticky: strobe stayed high after a block completed
overflow  output  1  sticky: completed block dropped because the FIFO was full

Behaviour:
- Reset (rst=0, asynchronous): all of the following clear immediately.
  - Outputs: out_valid=0, out_data=0, block_count=0, all flags 0.
  - Internal: FSM to IDLE, byte counter 0, assembly register 0, FIFO emptied.
- Byte capture: byte index k (0..15) is written to asm[127-8k -: 8]. The capture counter is 4 bits.
- FSM states: IDLE, COLLECT, DRAIN.
- IDLE:
  - ct_strobe_in=1 with SKIP_FIRST=1: discard the byte, go to COLLECT with cnt=0.
  - ct_strobe_in=1 with SKIP_FIRST=0: capture the byte as k=0, go to COLLECT with cnt=1.
  - Otherwise stay in IDLE.
- COLLECT:
  - ct_strobe_in=1: capture at k=cnt, then cnt++.
  - Capture with cnt=15: push {asm with final byte merged} into the FIFO, go to DRAIN.
  - ct_strobe_in=0: set short_err, discard the partial block, cnt=0, go to IDLE.
- DRAIN:
  - ct_strobe_in=0: go to IDLE.
  - ct_strobe_in=1: set long_err, ignore the byte, stay in DRAIN.
- A nominal core burst is 17 strobe-high cycles (1 stale + 16 valid). It ends with DRAIN→IDLE on the first strobe-low cycle, with no error.
- Back-to-back bursts need at least 1 strobe-low cycle in between. A strobe that never drops holds the block in DRAIN.
- FIFO push/pop:
  - pop = out_valid & out_ready.
  - A push when the FIFO is full and there is no pop: drop the block, set overflow, block_count unchanged.
  - Simultaneous push and pop when full: pop head, accept the push, count it.
  - Simultaneous push and pop with 1 entry: occupancy stays 1, the new block becomes head.
  - Pop when empty: ignored.
- out_data is the registered head, and is 0 when the FIFO is empty.
- Latency: the last byte is sampled at edge E. If the FIFO was empty, out_valid=1 and out_data is valid after E, in the following cycle.
- block_count increments by 1 per accepted push and wraps from 16'hFFFF to 0.
- clear=1: flags and block_count go to 0 next edge.
  - FIFO and FSM are unaffected.
  - If an error event and clear occur in the same cycle, clear wins.
  - If a push and clear occur in the same cycle, block_count is 0.
- out_data and out_valid hold stable while out_valid=1 and out_ready=0.

Test Plan:
- Nominal burst: SKIP_FIRST=1, out_ready=1; strobe 17 cycles carrying EE then 69 c4 e0 d8 6a 7b 04 30 d8 cd b7 80 70 b4 c5 5a → out_valid=1 for 1 cycle with out_data=69c4e0d86a7b0430d8cdb78070b4c55a, block_count=1, no flags.
- Short burst: strobe high 9 cycles (skip + 8 bytes) then low → short_err=1, out_valid stays 0, block_count=0; a following nominal burst is collected correctly.
- Overflow: out_ready=0, three nominal bursts with blocks A, B, C → overflow=1, block_count=2; popping yields A then B, then out_valid=0.
- Full FIFO with simultaneous push/pop: FIFO holds A and B, out_ready=1 on the edge C completes → A popped, C accepted, block_count=3, overflow=0; next reads return B, then C.
- Long burst: strobe high 20 cycles carrying 00,01..13 → out_data=0102030405060708090a0b0c0d0e0f10, long_err=1 after cycle 18; clear=1 → long_err=0, block_count=0, FIFO contents retained.
- Async reset mid-burst: drive rst=0 between edges after 5 captured bytes → all outputs 0 without waiting for an edge; release, run a nominal burst → correct block, block_count=1.

Source files
------------

// File: rtl/aes_cipher_collector_if.sv
`default_nettype none
// ============================================================================
//  Module      : aes_cipher_collector_if
//  Description : Ciphertext byte stream in, 128-bit block stream out, plus
//                status/control for the AES cipher collector.
//                The slave modport is the collector's view of these signals.
//                The master modport is the view of the core and consumer.
//  Revision    : 1.0  initial release
// ============================================================================
interface aes_cipher_collector_if;
    logic [7:0]   ct_byte_in;
    logic         ct_strobe_in;
    logic         clear;
    logic         out_ready;
    logic         out_valid;
    logic [127:0] out_data;
    logic [15:0]  block_count;
    logic         short_err;
    logic         long_err;
    logic         overflow;

    modport slave (
        input  ct_byte_in, ct_strobe_in, clear, out_ready,
        output out_valid, out_data, block_count, short_err, long_err, overflow
    );

    modport master (
        output ct_byte_in, ct_strobe_in, clear, out_ready,
        input  out_valid, out_data, block_count, short_err, long_err, overflow
    );
endinterface
`default_nettype wire

// File: rtl/aes_cipher_collector.sv
`default_nettype none
// ============================================================================
//  Module      : aes_cipher_collector
//  Description : Reassembles 16-byte ciphertext bursts from the byte-serial
//                AES core into 128-bit blocks, MSB byte first. Blocks are
//                buffered in a 2-entry FIFO with a valid/ready read side.
//                Sticky framing and overflow flags and a block counter are
//                also provided.
//  Revision    : 1.0  initial release
// ============================================================================
module aes_cipher_collector #(
    parameter int SKIP_FIRST = 1,
    parameter int FIFO_DEPTH = 2
) (
    input  wire logic             clk,
    input  wire logic             rst,
    aes_cipher_collector_if.slave bus
);

    localparam logic [1:0] C_DEPTH = 2'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2
    } state_t;

    state_t        r_state;
    state_t        w_stateNext;
    logic [3:0]    r_cnt;
    logic [3:0]    w_cntNext;
    logic [127:0]  r_asm;
    logic [127:0]  w_asmNext;
    logic [127:0]  w_block;
    logic [6:0]    w_bitIdx;
    logic          w_push;
    logic          w_shortEv;
    logic          w_longEv;

    logic [127:0]  r_mem0;
    logic [127:0]  r_mem1;
    logic [1:0]    r_count;
    logic [127:0]  w_mem0Next;
    logic [127:0]  w_mem1Next;
    logic [1:0]    w_countNext;
    logic          w_pop;
    logic          w_full;
    logic          w_accept;
    logic          w_drop;

    logic [15:0]   r_blockCount;
    logic          r_shortErr;
    logic          r_longErr;
    logic          r_overflow;

    // Next-state, capture position and framing events of the burst FSM
    always_comb begin
        w_stateNext = r_state;
        w_cntNext   = r_cnt;
        w_asmNext   = r_asm;
        w_push      = 1'b0;
        w_shortEv   = 1'b0;
        w_longEv    = 1'b0;
        // Byte k lands at bits [127-8k -: 8]; w_block is r_asm with the
        // current byte merged, which is also what gets pushed on byte 15.
        w_bitIdx    = 7'd127 - {r_cnt, 3'b000};
        w_block     = r_asm;
        w_block[w_bitIdx -: 8] = bus.ct_byte_in;

        case (r_state)
            S_IDLE: begin
                if (bus.ct_strobe_in) begin
                    w_stateNext = S_COLLECT;
                    if (SKIP_FIRST != 0) begin
                        // First strobe cycle carries a stale byte
                        w_cntNext = 4'd0;
                    end else begin
                        w_asmNext[127:120] = bus.ct_byte_in;
                        w_cntNext          = 4'd1;
                    end
                end
            end
            S_COLLECT: begin
                if (bus.ct_strobe_in) begin
                    w_asmNext = w_block;
                    w_cntNext = r_cnt + 4'd1;
                    if (r_cnt == 4'd15) begin
                        w_push      = 1'b1;
                        w_stateNext = S_DRAIN;
                    end
                end else begin
                    w_shortEv   = 1'b1;
                    w_cntNext   = 4'd0;
                    w_stateNext = S_IDLE;
                end
            end
            S_DRAIN: begin
                // Block already delivered; wait for the strobe to drop
                if (bus.ct_strobe_in) begin
                    w_longEv = 1'b1;
                end else begin
                    w_stateNext = S_IDLE;
                end
            end
            default: begin
                w_stateNext = S_IDLE;
                w_cntNext   = 4'd0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_stateNext;
        end
    end

    // Capture counter and assembly register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt <= 4'd0;
            r_asm <= 128'd0;
        end else begin
            r_cnt <= w_cntNext;
            r_asm <= w_asmNext;
        end
    end

    // Two-entry shift FIFO; head is always r_mem0, empty slots are kept at 0
    always_comb begin
        w_pop       = (r_count != 2'd0) && bus.out_ready;
        w_full      = (r_count == C_DEPTH);
        w_accept    = w_push && (!w_full || w_pop);
        w_drop      = w_push && w_full && !w_pop;
        w_mem0Next  = r_mem0;
        w_mem1Next  = r_mem1;
        w_countNext = r_count;

        case ({w_accept, w_pop})
            2'b10: begin
                if (r_count == 2'd0) begin
                    w_mem0Next = w_block;
                end else begin
                    w_mem1Next = w_block;
                end
                w_countNext = r_count + 2'd1;
            end
            2'b01: begin
                w_mem0Next  = r_mem1;
                w_mem1Next  = 128'd0;
                w_countNext = r_count - 2'd1;
            end
            2'b11: begin
                if (r_count == 2'd1) begin
                    w_mem0Next = w_block;
                end else begin
                    w_mem0Next = r_mem1;
                    w_mem1Next = w_block;
                end
            end
            default: begin
                w_countNext = r_count;
            end
        endcase
    end

    // FIFO storage and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_mem0  <= 128'd0;
            r_mem1  <= 128'd0;
            r_count <= 2'd0;
        end else begin
            r_mem0  <= w_mem0Next;
            r_mem1  <= w_mem1Next;
            r_count <= w_countNext;
        end
    end

    // Sticky flags and block counter; clear takes priority over new events
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_blockCount <= 16'd0;
            r_shortErr   <= 1'b0;
            r_longErr    <= 1'b0;
            r_overflow   <= 1'b0;
        end else if (bus.clear) begin
            r_blockCount <= 16'd0;
            r_shortErr   <= 1'b0;
            r_longErr    <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_blockCount <= r_blockCount + 16'd1;
            end
            r_shortErr <= r_shortErr | w_shortEv;
            r_longErr  <= r_longErr  | w_longEv;
            r_overflow <= r_overflow | w_drop;
        end
    end

    assign bus.out_valid   = (r_count != 2'd0);
    assign bus.out_data    = r_mem0;
    assign bus.block_count = r_blockCount;
    assign bus.short_err   = r_shortErr;
    assign bus.long_err    = r_longErr;
    assign bus.overflow    = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_aes_cipher_collector.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aes_cipher_collector
//  Description : Directed bench for aes_cipher_collector: table of nominal
//                bursts plus hand-written short/long/overflow/clear/reset
//                sequences.
//  Revision    : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_aes_cipher_collector;

    logic clk;
    logic rst;
    int   nChecks;
    int   nErrs;

    aes_cipher_collector_if bus();

    aes_cipher_collector #(
        .SKIP_FIRST (1),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]   stale;
        logic [127:0] blk;
        logic [127:0] expData;
        logic [15:0]  expCount;
    } vec_t;

    vec_t vecs [4];

    logic [127:0] blkA;
    logic [127:0] blkB;
    logic [127:0] blkC;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // stale byte then 16 block bytes MSB first; strobe is left high on return
    task automatic burst(input logic [7:0] stale, input logic [127:0] blk, input logic readyOnLast);
        bus.ct_strobe_in = 1'b1;
        bus.ct_byte_in   = stale;
        tick();
        for (int k = 0; k < 16; k++) begin
            bus.ct_byte_in = blk[127 - 8*k -: 8];
            if (k == 15 && readyOnLast) bus.out_ready = 1'b1;
            tick();
        end
    endtask

    task automatic endBurst();
        bus.ct_strobe_in = 1'b0;
        bus.ct_byte_in   = 8'h00;
        tick();
    endtask

    task automatic doClear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
    endtask

    function automatic logic [2:0] flags();
        return {bus.short_err, bus.long_err, bus.overflow};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        nChecks = 0;
        nErrs   = 0;
        blkA = 128'h00112233445566778899aabbccddeeff;
        blkB = 128'hfedcba98765432100123456789abcdef;
        blkC = 128'h0f0e0d0c0b0a09080706050403020100;

        vecs[0] = '{8'hEE, 128'h69c4e0d86a7b0430d8cdb78070b4c55a,
                    128'h69c4e0d86a7b0430d8cdb78070b4c55a, 16'd1};
        vecs[1] = '{8'h00, 128'hffffffffffffffffffffffffffffffff,
                    128'hffffffffffffffffffffffffffffffff, 16'd2};
        vecs[2] = '{8'h5a, 128'h000102030405060708090a0b0c0d0e0f,
                    128'h000102030405060708090a0b0c0d0e0f, 16'd3};
        vecs[3] = '{8'h12, 128'h0123456789abcdeffedcba9876543210,
                    128'h0123456789abcdeffedcba9876543210, 16'd4};

        rst              = 1'b0;
        bus.ct_byte_in   = 8'h00;
        bus.ct_strobe_in = 1'b0;
        bus.clear        = 1'b0;
        bus.out_ready    = 1'b0;

        // ---------------- reset state ----------------
        #12;
        check("reset_valid", bus.out_valid, 1'b0);
        check("reset_data", bus.out_data, 128'd0);
        check("reset_count", bus.block_count, 16'd0);
        check("reset_flags", flags(), 3'b000);
        rst = 1'b1;
        tick();

        // ---------------- nominal bursts from table ----------------
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            burst(vecs[i].stale, vecs[i].blk, 1'b1);
            check($sformatf("nom%0d_valid", i), bus.out_valid, 1'b1);
            check($sformatf("nom%0d_data", i), bus.out_data, vecs[i].expData);
            check($sformatf("nom%0d_count", i), bus.block_count, vecs[i].expCount);
            check($sformatf("nom%0d_flags", i), flags(), 3'b000);
            endBurst();
            check($sformatf("nom%0d_popped", i), bus.out_valid, 1'b0);
            check($sformatf("nom%0d_empty_data", i), bus.out_data, 128'd0);
        end

        doClear();
        check("clear_count", bus.block_count, 16'd0);

        // ---------------- short burst ----------------
        bus.ct_strobe_in = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bus.ct_byte_in = 8'(i + 8'h30);
            tick();
        end
        endBurst();
        check("short_err", bus.short_err, 1'b1);
        check("short_valid", bus.out_valid, 1'b0);
        check("short_count", bus.block_count, 16'd0);
        burst(vecs[0].stale, vecs[0].blk, 1'b1);
        check("after_short_data", bus.out_data, vecs[0].expData);
        check("after_short_count", bus.block_count, 16'd1);
        endBurst();
        doClear();
        check("clear_short", bus.short_err, 1'b0);

        // ---------------- overflow ----------------
        bus.out_ready = 1'b0;
        burst(8'hEE, blkA, 1'b0); endBurst();
        burst(8'hEE, blkB, 1'b0); endBurst();
        burst(8'hEE, blkC, 1'b0);
        check("ovf_flag", bus.overflow, 1'b1);
        endBurst();
        check("ovf_count", bus.block_count, 16'd2);
        check("ovf_headA", bus.out_data, blkA);
        bus.out_ready = 1'b1;
        tick();
        check("ovf_headB", bus.out_data, blkB);
        tick();
        check("ovf_empty", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;
        doClear();

        // ---------------- full FIFO with simultaneous push/pop ----------------
        burst(8'hEE, blkA, 1'b0); endBurst();
        burst(8'hEE, blkB, 1'b0); endBurst();
        burst(8'hEE, blkC, 1'b1);
        bus.out_ready = 1'b0;
        check("pp_headB", bus.out_data, blkB);
        check("pp_count", bus.block_count, 16'd3);
        check("pp_no_ovf", bus.overflow, 1'b0);
        endBurst();
        bus.out_ready = 1'b1;
        tick();
        check("pp_headC", bus.out_data, blkC);
        tick();
        check("pp_empty", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // ---------------- long burst ----------------
        bus.ct_strobe_in = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.ct_byte_in = 8'(i);
            tick();
            if (i == 16) begin
                check("long_data", bus.out_data, 128'h0102030405060708090a0b0c0d0e0f10);
                check("long_not_yet", bus.long_err, 1'b0);
            end
            if (i == 17) check("long_err", bus.long_err, 1'b1);
        end
        endBurst();
        check("long_count", bus.block_count, 16'd4);
        doClear();
        check("clr_long", bus.long_err, 1'b0);
        check("clr_count", bus.block_count, 16'd0);
        check("clr_fifo_kept", bus.out_data, 128'h0102030405060708090a0b0c0d0e0f10);

        // ---------------- clear beats a simultaneous short error ----------------
        bus.ct_strobe_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.ct_byte_in = 8'(i);
            tick();
        end
        bus.ct_strobe_in = 1'b0;
        bus.clear        = 1'b1;
        tick();
        bus.clear = 1'b0;
        check("clear_wins_short", bus.short_err, 1'b0);
        bus.out_ready = 1'b1;
        tick();
        check("drain_valid", bus.out_valid, 1'b0);
        bus.out_ready = 1'b0;

        // ---------------- async reset mid-burst ----------------
        burst(8'hEE, blkA, 1'b0);
        tick();
        endBurst();
        check("prerst_long", bus.long_err, 1'b1);
        bus.ct_strobe_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            bus.ct_byte_in = 8'(8'hA0 + i);
            tick();
        end
        #2;
        rst = 1'b0;
        #1;
        check("arst_valid", bus.out_valid, 1'b0);
        check("arst_data", bus.out_data, 128'd0);
        check("arst_count", bus.block_count, 16'd0);
        check("arst_flags", flags(), 3'b000);
        bus.ct_strobe_in = 1'b0;
        #3;
        rst = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b1;
        burst(8'hEE, blkB, 1'b1);
        check("postrst_data", bus.out_data, blkB);
        check("postrst_count", bus.block_count, 16'd1);
        check("postrst_flags", flags(), 3'b000);
        endBurst();

        $display("Result: errors=%0d of %0d checks", nErrs, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
